uart_link_bist: RTL and testbench

Synthesizable built-in self-test engine for a UART TX/RX link. It generates a parametrised data pattern into the transmit FIFO, drains the receive FIFO, and compares each received frame against an identical locally regenerated sequence. It reports frame count, error count, timeout and pass/fail. It sits on the system clock between the bus side of the TX FIFO and the bus side of the RX FIFO, in place of the bus master, during link test.

---
 rtl/uart_bist_pkg.sv | 19 +
 rtl/uart_link_bist_if.sv | 22 ++
 rtl/uart_pattern_gen.sv | 40 ++++
 rtl/uart_link_bist.sv | 139 +++++++++++++
 tb/tb_uart_link_bist.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bist_pkg.sv
// rtl/uart_bist_pkg.sv - shared types and constants for the UART link self-test engine
package uart_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_INC   = 2'b00,
        MODE_LFSR  = 2'b01,
        MODE_FIXED = 2'b10,
        MODE_WALK  = 2'b11
    } mode_t;

    localparam logic [7:0] DEFAULT_TAP_MASK = 8'hB8;

endpackage

// File: rtl/uart_link_bist_if.sv
// rtl/uart_link_bist_if.sv - bus-side TX/RX FIFO signals seen by the self-test engine
interface uart_link_bist_if #(
    parameter int DATA_SIZE = 8
);
    logic [DATA_SIZE-1:0] tx_data;
    logic                 tx_write;
    logic                 tx_full;
    logic [DATA_SIZE-1:0] rx_data;
    logic                 rx_read;
    logic                 rx_empty;
    logic                 rx_error;

    modport master (
        output tx_data, tx_write, rx_read,
        input  tx_full, rx_data, rx_empty, rx_error
    );

    modport slave (
        input  tx_data, tx_write, rx_read,
        output tx_full, rx_data, rx_empty, rx_error
    );
endinterface

// File: rtl/uart_pattern_gen.sv
// rtl/uart_pattern_gen.sv - pattern register, loaded with a seed and stepped per mode
module uart_pattern_gen
    import uart_bist_pkg::*;
#(
    parameter int                   DATA_SIZE = 8,
    parameter logic [DATA_SIZE-1:0] TAP_MASK  = DATA_SIZE'(DEFAULT_TAP_MASK)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 advance,
    input  mode_t                mode,
    input  logic [DATA_SIZE-1:0] seed,
    output logic [DATA_SIZE-1:0] value
);
    logic [DATA_SIZE-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            // An all-zero LFSR would lock up, so it starts from 1 instead
            value_d = (mode == MODE_LFSR && seed == '0) ? DATA_SIZE'(1) : seed;
        end else if (advance) begin
            case (mode)
                MODE_INC:   value_d = value_q + DATA_SIZE'(1);
                MODE_LFSR:  value_d = {value_q[DATA_SIZE-2:0], ^(value_q & TAP_MASK)};
                MODE_FIXED: value_d = value_q;
                MODE_WALK:  value_d = {value_q[DATA_SIZE-2:0], value_q[DATA_SIZE-1]};
                default:    value_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) value_q <= '0;
        else          value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/uart_link_bist.sv
// rtl/uart_link_bist.sv - UART link self-test: drives a pattern into TX, checks RX against a replica
module uart_link_bist
    import uart_bist_pkg::*;
#(
    parameter int                   DATA_SIZE      = 8,
    parameter int                   COUNT_WIDTH    = 16,
    parameter logic [DATA_SIZE-1:0] TAP_MASK       = DATA_SIZE'(DEFAULT_TAP_MASK),
    parameter int                   TIMEOUT_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [DATA_SIZE-1:0]   seed,
    input  logic [COUNT_WIDTH-1:0] num_frames,
    uart_link_bist_if.master       fifo,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] err_count
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    logic [COUNT_WIDTH-1:0] num_q, num_d;
    logic [COUNT_WIDTH-1:0] sent_q, sent_d;
    logic [COUNT_WIDTH-1:0] frame_q, frame_d;
    logic [COUNT_WIDTH-1:0] err_q, err_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   timeout_q, timeout_d;
    logic                   pass_q, pass_d;

    logic                   accept;
    mode_t                  mode_sel;
    logic [DATA_SIZE-1:0]   exp_value;
    logic                   mismatch;

    assign accept   = start && (state_q != RUN);
    // Generators must see the incoming mode on the load cycle for the LFSR zero-seed fix
    assign mode_sel = accept ? mode_t'(mode) : mode_q;

    assign fifo.tx_write = (state_q == RUN) && (sent_q < num_q) && !fifo.tx_full;
    assign fifo.rx_read  = (state_q == RUN) && (frame_q < num_q) && !fifo.rx_empty;
    assign mismatch      = (fifo.rx_data != exp_value) || fifo.rx_error;

    uart_pattern_gen #(.DATA_SIZE(DATA_SIZE), .TAP_MASK(TAP_MASK)) u_tx_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .advance (fifo.tx_write),
        .mode    (mode_sel),
        .seed    (seed),
        .value   (fifo.tx_data)
    );

    uart_pattern_gen #(.DATA_SIZE(DATA_SIZE), .TAP_MASK(TAP_MASK)) u_rx_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .advance (fifo.rx_read),
        .mode    (mode_sel),
        .seed    (seed),
        .value   (exp_value)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        sent_d    = sent_q;
        frame_d   = frame_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        if (accept) begin
            mode_d    = mode_t'(mode);
            num_d     = num_frames;
            sent_d    = '0;
            frame_d   = '0;
            err_d     = '0;
            tmo_d     = '0;
            timeout_d = 1'b0;
            // An empty run has nothing to wait for and is trivially good
            pass_d    = (num_frames == '0);
            state_d   = (num_frames == '0) ? DONE : RUN;
        end else if (state_q == RUN) begin
            if (fifo.tx_write) sent_d = sent_q + COUNT_WIDTH'(1);
            if (fifo.rx_read) begin
                frame_d = frame_q + COUNT_WIDTH'(1);
                if (mismatch && err_q != '1) err_d = err_q + COUNT_WIDTH'(1);
                tmo_d = '0;
                if (frame_d == num_q) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = DONE;
                timeout_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE_INC;
            num_q     <= '0;
            sent_q    <= '0;
            frame_q   <= '0;
            err_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            sent_q    <= sent_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign frame_count = frame_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_uart_link_bist.sv
// tb/tb_uart_link_bist.sv - directed bench for uart_link_bist with a FIFO/loopback model
module tb_uart_link_bist;
    localparam int DS  = 8;
    localparam int CW  = 16;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode_in = 2'b00;
    logic [DS-1:0] seed_in = '0;
    logic [CW-1:0] num_in = '0;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] frame_count, err_count;

    logic          force_full = 1'b0;
    logic          hold_rx = 1'b0;
    logic          disconnect = 1'b0;
    logic          clr_req = 1'b0;
    int            corrupt_idx = -1;
    logic [DS-1:0] rx_head_q = '0;
    logic          rxq_empty_q = 1'b1;
    logic [DS-1:0] txlog[$];
    logic [DS-1:0] rxq[$];
    int            wr_idx = 0;
    int            full_viol = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            lat;

    uart_link_bist_if #(.DATA_SIZE(DS)) bus ();

    assign bus.tx_full  = force_full;
    assign bus.rx_data  = rx_head_q;
    assign bus.rx_empty = rxq_empty_q || hold_rx;
    assign bus.rx_error = 1'b0;

    uart_link_bist #(
        .DATA_SIZE      (DS),
        .COUNT_WIDTH    (CW),
        .TAP_MASK       (8'hB8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode_in),
        .seed        (seed_in),
        .num_frames  (num_in),
        .fifo        (bus),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // TX FIFO -> serial link -> RX FIFO, collapsed into one queue with optional bit error
    always @(posedge clk) begin : link
        logic [DS-1:0] tmp;
        if (clr_req) begin
            rxq.delete();
            txlog.delete();
            wr_idx = 0;
        end else begin
            if (bus.rx_read) tmp = rxq.pop_front();
            if (bus.tx_write) begin
                txlog.push_back(bus.tx_data);
                if (!disconnect)
                    rxq.push_back((wr_idx == corrupt_idx) ? (bus.tx_data ^ 8'h01) : bus.tx_data);
                wr_idx = wr_idx + 1;
            end
        end
        rxq_empty_q <= (rxq.size() == 0);
        rx_head_q   <= (rxq.size() != 0) ? rxq[0] : '0;
    end

    always @(negedge clk) begin
        if (bus.tx_full && bus.tx_write) full_viol = full_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_link();
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        corrupt_idx = -1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [DS-1:0] s, input logic [CW-1:0] n);
        mode_in = m;
        seed_in = s;
        num_in  = n;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1 n = n + 1;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_tx_write", {31'd0, bus.tx_write}, 32'd0);
        check("rst_rx_read", {31'd0, bus.rx_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_frames", 32'(frame_count), 32'd0);
        check("rst_errs", 32'(err_count), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        clear_link();

        // Incrementing pattern
        do_start(2'b00, 8'h10, 16'd4);
        check("inc_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("inc_b0", 32'(txlog[0]), 32'h10);
        check("inc_b3", 32'(txlog[3]), 32'h13);
        check("inc_nsent", 32'(txlog.size()), 32'd4);
        check("inc_pass", {31'd0, pass}, 32'd1);
        check("inc_frames", 32'(frame_count), 32'd4);
        check("inc_errs", 32'(err_count), 32'd0);
        check("inc_busy_end", {31'd0, busy}, 32'd0);

        // LFSR with zero seed: 01 02 04 08 11 23 ...
        clear_link();
        do_start(2'b01, 8'h00, 16'd20);
        wait_done(lat);
        check("lfsr_b0", 32'(txlog[0]), 32'h01);
        check("lfsr_b4", 32'(txlog[4]), 32'h11);
        check("lfsr_b5", 32'(txlog[5]), 32'h23);
        check("lfsr_pass", {31'd0, pass}, 32'd1);
        check("lfsr_frames", 32'(frame_count), 32'd20);

        // Walking one, third frame corrupted on the line
        clear_link();
        corrupt_idx = 2;
        do_start(2'b11, 8'h01, 16'd8);
        wait_done(lat);
        check("walk_b7", 32'(txlog[7]), 32'h80);
        check("walk_errs", 32'(err_count), 32'd1);
        check("walk_pass", {31'd0, pass}, 32'd0);
        check("walk_frames", 32'(frame_count), 32'd8);
        corrupt_idx = -1;

        // Disconnected link times out
        clear_link();
        disconnect = 1'b1;
        do_start(2'b00, 8'h00, 16'd2);
        wait_done(lat);
        check("tmo_latency", 32'(lat), 32'(TMO));
        check("tmo_flag", {31'd0, timeout}, 32'd1);
        check("tmo_pass", {31'd0, pass}, 32'd0);
        check("tmo_frames", 32'(frame_count), 32'd0);
        disconnect = 1'b0;

        // TX backpressure mid-run, with wrap of the incrementing pattern
        clear_link();
        full_viol = 0;
        do_start(2'b00, 8'hFE, 16'd6);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 force_full = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("full_stall", 32'(txlog.size()), 32'd2);
        force_full = 1'b0;
        wait_done(lat);
        check("full_viol", 32'(full_viol), 32'd0);
        check("full_wrap", 32'(txlog[2]), 32'h00);
        check("full_pass", {31'd0, pass}, 32'd1);
        check("full_frames", 32'(frame_count), 32'd6);

        // start during RUN must be ignored
        clear_link();
        hold_rx = 1'b1;
        do_start(2'b00, 8'h20, 16'd3);
        repeat (3) @(posedge clk);
        #1;
        do_start(2'b10, 8'hAA, 16'd5);
        check("ign_busy", {31'd0, busy}, 32'd1);
        hold_rx = 1'b0;
        wait_done(lat);
        check("ign_frames", 32'(frame_count), 32'd3);
        check("ign_b2", 32'(txlog[2]), 32'h22);
        check("ign_pass", {31'd0, pass}, 32'd1);

        // Reset mid-run, then an empty run
        clear_link();
        do_start(2'b00, 8'h00, 16'd10);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_frames", 32'(frame_count), 32'd3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_frames", 32'(frame_count), 32'd0);
        check("mid_rst_tx_write", {31'd0, bus.tx_write}, 32'd0);
        check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        clear_link();
        do_start(2'b00, 8'h00, 16'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_pass", {31'd0, pass}, 32'd1);
        check("zero_tx_write", {31'd0, bus.tx_write}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
